phv_merge: RTL and testbench

Write-back stage directly downstream of the per-container ALU bank in each RMT action stage. Accepts each PHV at the moment its actions are issued and holds it for the fixed ALU latency. When the results arrive, it overwrites the containers selected by the write mask and queues the merged PHV in an output FIFO for the next stage. Upstream issue is credit-throttled so ALU results are never dropped; the ALUs themselves cannot stall.

---
 rtl/phv_merge_pkg.sv | 23 ++
 rtl/phv_sync_fifo.sv | 61 ++++++
 rtl/phv_merge.sv | 117 +++++++++++
 tb/tb_phv_merge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/phv_merge_pkg.sv
// Shared definitions for the PHV write-back stage.
// Container width, ALU opcodes and the container slice helper.
package phv_merge_pkg;

  localparam int PHV_C_WIDTH = 48;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBI = 4'b1010;

  // Any non-pass opcode writes its container.
  function automatic logic op_writes(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) ||
           (op == OP_SUB) || (op == OP_SUBI);
  endfunction

  // Low bit of container i in a flat PHV bus.
  function automatic int cont_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/phv_sync_fifo.sv
// Synchronous FIFO with a registered head word and occupancy count.
// Ports: clk, rst, push/push_data, pop, head, valid, count.
module phv_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt;

  assign rd_nxt = rd_ptr + 1'b1;
  assign valid  = (cnt != '0);
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Head tracks the entry at rd_ptr; a push into an empty
      // (or about-to-be-empty) FIFO lands directly in head.
      if (pop) begin
        if (cnt > CNT_ONE)
          head <= mem[rd_nxt];
        else if (push)
          head <= push_data;
      end else if (push && cnt == '0) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/phv_merge.sv
// ALU write-back: delays each PHV by ALU_LAT, merges masked ALU
// results, queues it credit-throttled. Ports: issue, ALU bus, output.
module phv_merge
  import phv_merge_pkg::*;
#(
  parameter int STAGE    = 0,
  parameter int NUM_CONT = 8,
  parameter int C_WIDTH  = PHV_C_WIDTH,
  parameter int ALU_LAT  = 2,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CONT*C_WIDTH-1:0] phv_in,
  input  logic                        phv_in_valid,
  input  logic [NUM_CONT-1:0]         wr_mask_in,
  output logic                        issue_ready,
  input  logic [NUM_CONT*C_WIDTH-1:0] alu_container_in,
  input  logic [NUM_CONT-1:0]         alu_valid_in,
  output logic [NUM_CONT*C_WIDTH-1:0] phv_out,
  output logic                        phv_out_valid,
  input  logic                        phv_out_ready,
  output logic                        err_missing
);

  localparam int PW = NUM_CONT * C_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]       dl_phv  [ALU_LAT];
  logic [NUM_CONT-1:0] dl_mask [ALU_LAT];
  logic [ALU_LAT-1:0]  dl_vld;

  logic          fire;
  logic          arrive;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] merged;
  logic          missing;
  logic          err_q;
  int unsigned   occ;

  assign fire   = phv_in_valid && issue_ready;
  assign arrive = dl_vld[ALU_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld <= '0;
    end else begin
      dl_vld[0] <= fire;
      for (int k = 1; k < ALU_LAT; k++)
        dl_vld[k] <= dl_vld[k-1];
    end
  end

  // Payload is qualified by dl_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    dl_phv[0]  <= phv_in;
    dl_mask[0] <= wr_mask_in;
    for (int k = 1; k < ALU_LAT; k++) begin
      dl_phv[k]  <= dl_phv[k-1];
      dl_mask[k] <= dl_mask[k-1];
    end
  end

  always_comb begin
    merged = dl_phv[ALU_LAT-1];
    for (int i = 0; i < NUM_CONT; i++) begin
      if (dl_mask[ALU_LAT-1][i])
        merged[cont_lo(i, C_WIDTH) +: C_WIDTH] =
          alu_container_in[cont_lo(i, C_WIDTH) +: C_WIDTH];
    end
  end

  assign missing =
    arrive && |(dl_mask[ALU_LAT-1] & ~alu_valid_in);

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (missing)
      err_q <= 1'b1;
  end

  assign err_missing = err_q;

  // Credits: every in-flight PHV already owns a FIFO slot.
  always_comb begin
    occ = 32'(fifo_count);
    for (int k = 0; k < ALU_LAT; k++)
      occ = occ + 32'(dl_vld[k]);
    issue_ready = (occ < 32'(DEPTH));
  end

  assign fifo_pop = phv_out_valid && phv_out_ready;

  phv_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (arrive),
    .push_data (merged),
    .pop       (fifo_pop),
    .head      (phv_out),
    .valid     (phv_out_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(arrive && !fifo_pop &&
                fifo_count == CW'(DEPTH)))
      else $error("phv_merge %0d: push into full fifo", STAGE);
  end

endmodule

// File: tb/tb_phv_merge.sv
// Randomized bench for phv_merge against a queue-based model.
// Model tracks pending issues by due cycle and the output FIFO.
module tb_phv_merge;

  localparam int N   = 8;
  localparam int W   = 48;
  localparam int PW  = N * W;
  localparam int D   = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] phv_in;
  logic          phv_in_valid;
  logic [N-1:0]  wr_mask_in;
  logic          issue_ready;
  logic [PW-1:0] alu_container_in;
  logic [N-1:0]  alu_valid_in;
  logic [PW-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready;
  logic          err_missing;

  always #5 clk = ~clk;

  phv_merge #(
    .STAGE    (0),
    .NUM_CONT (N),
    .C_WIDTH  (W),
    .ALU_LAT  (LAT),
    .DEPTH    (D)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .phv_in           (phv_in),
    .phv_in_valid     (phv_in_valid),
    .wr_mask_in       (wr_mask_in),
    .issue_ready      (issue_ready),
    .alu_container_in (alu_container_in),
    .alu_valid_in     (alu_valid_in),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
    .phv_out_ready    (phv_out_ready),
    .err_missing      (err_missing)
  );

  typedef struct {
    logic [PW-1:0] p;
    logic [N-1:0]  m;
    int            due;
  } pend_t;

  pend_t         pend[$];
  logic [PW-1:0] mq[$];
  logic          m_err;
  int            cyc;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag,
                       input logic [PW-1:0] got,
                       input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_phv(input int base);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  function automatic logic [PW-1:0] rnd_bus();
    logic [PW-1:0] v;
    for (int k = 0; k < PW / 32; k++)
      v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Expand container mask to a bit mask and blend.
  function automatic logic [PW-1:0] blend(input logic [PW-1:0] p,
                                          input logic [PW-1:0] a,
                                          input logic [N-1:0] m);
    logic [PW-1:0] bm;
    for (int b = 0; b < PW; b++)
      bm[b] = m[b / W];
    return (a & bm) | (p & ~bm);
  endfunction

  // Called at a negedge: check visible state, drive, advance model.
  task automatic step(input logic v, input logic [PW-1:0] p,
                      input logic [N-1:0] m, input logic r,
                      input logic [PW-1:0] a,
                      input logic [N-1:0] av);
    logic  fire;
    logic  pop;
    pend_t pe;
    fire = v && ((mq.size() + pend.size()) < D);
    check("issue_ready", PW'(issue_ready), PW'(fire || !v ?
          ((mq.size() + pend.size()) < D) : 1'b0));
    check("out_valid", PW'(phv_out_valid), PW'(mq.size() != 0));
    if (mq.size() != 0)
      check("phv_out", phv_out, mq[0]);
    check("err_missing", PW'(err_missing), PW'(m_err));
    phv_in_valid     = v;
    phv_in           = p;
    wr_mask_in       = m;
    phv_out_ready    = r;
    alu_container_in = a;
    alu_valid_in     = av;
    pop = (mq.size() != 0) && r;
    if (pop) void'(mq.pop_front());
    if (pend.size() != 0 && pend[0].due == cyc) begin
      pe = pend.pop_front();
      if ((pe.m & ~av) != '0) m_err = 1'b1;
      mq.push_back(blend(pe.p, a, pe.m));
    end
    if (fire) begin
      pe.p   = p;
      pe.m   = m;
      pe.due = cyc + LAT;
      pend.push_back(pe);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++)
      step(1'b0, rnd_bus(), N'($urandom), r, rnd_bus(), N'($urandom));
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    phv_in_valid     = 1'b0;
    phv_in           = rnd_bus();
    wr_mask_in       = '1;
    phv_out_ready    = 1'b0;
    alu_container_in = rnd_bus();
    alu_valid_in     = '1;
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    mq.delete();
    m_err = 1'b0;
    cyc++;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_err    = 1'b0;
    rst      = 1'b1;
    phv_in_valid  = 1'b0;
    phv_in        = '0;
    wr_mask_in    = '0;
    phv_out_ready = 1'b0;
    alu_container_in = '0;
    alu_valid_in  = '0;
    repeat (2) @(negedge clk);
    do_reset();
    check("reset_phv_out", phv_out, '0);

    // Mask 0101: containers 0 and 2 take ALU results.
    step(1'b1, mk_phv(1), 8'h05, 1'b0, rnd_bus(), 8'h00);
    step(1'b0, '0, '0, 1'b0, rnd_bus(), 8'h00);
    step(1'b0, '0, '0, 1'b0, mk_phv(32'h100), 8'hFF);
    check("mask05_out", phv_out, (mk_phv(1) & ~(PW'(48'hFFFF_FFFF_FFFF)
          | (PW'(48'hFFFF_FFFF_FFFF) << (2*W)))) | PW'(48'h100)
          | (PW'(48'h102) << (2*W)));
    idle(2, 1'b1);

    // Empty mask with no ALU valids passes the PHV through.
    step(1'b1, mk_phv(32'h55), 8'h00, 1'b1, rnd_bus(), 8'h00);
    step(1'b0, '0, '0, 1'b1, rnd_bus(), 8'h00);
    step(1'b0, '0, '0, 1'b0, rnd_bus(), 8'h00);
    check("passthru_out", phv_out, mk_phv(32'h55));
    idle(2, 1'b1);

    // Backpressure: four accepted, then stall; one pop frees one.
    for (int k = 0; k < 8; k++)
      step(1'b1, mk_phv(k * 16), 8'h00, 1'b0, rnd_bus(), 8'h00);
    check("full_not_ready", PW'(issue_ready), '0);
    step(1'b0, '0, '0, 1'b1, rnd_bus(), 8'h00);
    check("pop_reopens", PW'(issue_ready), PW'(1));
    idle(8, 1'b1);

    // Random traffic with every masked lane valid.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] m;
      m = N'($urandom);
      step(($urandom % 4) != 0, rnd_bus(), m, ($urandom % 3) != 0,
           rnd_bus(), m | N'($urandom));
    end
    idle(10, 1'b1);

    // Lane 3 masked but not valid at arrival.
    step(1'b1, mk_phv(7), 8'h08, 1'b0, rnd_bus(), 8'hFF);
    step(1'b0, '0, '0, 1'b0, rnd_bus(), 8'hFF);
    step(1'b0, '0, '0, 1'b0, mk_phv(32'h300), 8'hF7);
    check("missing_set", PW'(err_missing), PW'(1));
    check("missing_data", phv_out[3*W +: W], PW'(48'h303));
    idle(4, 1'b1);
    check("missing_held", PW'(err_missing), PW'(1));

    // Flush two in-flight PHVs; late ALU valids must be ignored.
    step(1'b1, mk_phv(9), 8'hFF, 1'b1, rnd_bus(), 8'hFF);
    step(1'b1, mk_phv(10), 8'hFF, 1'b1, rnd_bus(), 8'hFF);
    do_reset();
    for (int k = 0; k < 4; k++)
      step(1'b0, '0, '0, 1'b1, rnd_bus(), 8'hFF);
    check("flush_no_valid", PW'(phv_out_valid), '0);
    check("flush_ready", PW'(issue_ready), PW'(1));
    check("flush_err_clr", PW'(err_missing), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
